// File: rtl/sg13g2_bist_pkg.sv
// -----------------------------------------------------------------------------
// sg13g2_bist_pkg
// Shared definitions for the sg13g2 cell BIST stage: controller state
// encoding, shift-register width, feedback tap mask and default seed.
// -----------------------------------------------------------------------------
package sg13g2_bist_pkg;

  localparam int unsigned SR_W = 16;

  // Taps at bits 15,13,12,10: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [SR_W-1:0] TAP_MASK = 16'hB400;

  // An all-zero LFSR is a lock-up state, so zero seeds map to this value
  localparam logic [SR_W-1:0] DEFAULT_SEED = 16'h0001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // One shift step: feedback is the parity of the tapped bits, then the
  // optional input vector is folded in (zero for a plain LFSR).
  function automatic logic [SR_W-1:0] sr_next(input logic [SR_W-1:0] cur,
                                               input logic [SR_W-1:0] xin);
    return {cur[SR_W-2:0], ^(cur & TAP_MASK)} ^ xin;
  endfunction

endpackage

// File: rtl/sg13g2_bist_lfsr16.sv
// -----------------------------------------------------------------------------
// sg13g2_bist_lfsr16
// 16-bit Fibonacci shift register with fixed tap mask, parallel load, shift
// enable and an XOR-in vector. Used as the stimulus LFSR (xin = 0) and as the
// response MISR (xin = zero-extended responses).
//   cp       : clock, rising edge
//   cdn      : asynchronous active-low reset, loads RST_VAL
//   load     : parallel load of load_val (wins over en)
//   load_val : value loaded when load = 1
//   en       : advance one step
//   xin      : vector XORed into the next state on each step
//   q        : current register value
// -----------------------------------------------------------------------------
module sg13g2_bist_lfsr16
  import sg13g2_bist_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        cp,
  input  logic        cdn,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  input  logic [15:0] xin,
  output logic [15:0] q
);

  logic [15:0] sr_r;

  // Shift register state: reset, load, step or hold
  always_ff @(posedge cp or negedge cdn) begin
    if (!cdn) begin
      sr_r <= RST_VAL;
    end else if (load) begin
      sr_r <= load_val;
    end else if (en) begin
      sr_r <= sr_next(sr_r, xin);
    end else begin
      sr_r <= sr_r;
    end
  end

  assign q = sr_r;

endmodule

// File: rtl/sg13g2_cell_bist.sv
// -----------------------------------------------------------------------------
// sg13g2_cell_bist
// BIST controller for a cell-under-test cluster: drives LFSR stimulus, compacts
// responses into a 16-bit MISR signature and compares it with a golden value.
//   cp, cdn   : clock (rising edge), asynchronous active-low reset
//   start     : level request, honoured only in IDLE
//   abort     : synchronous abort to IDLE from any state (beats start)
//   n_pat     : number of patterns, captured on start
//   seed      : LFSR seed, captured on start (0 maps to 16'h0001)
//   golden    : expected signature, compared in CMP
//   stim      : low N_IN bits of the LFSR
//   stim_vld  : stim carries a counted pattern this cycle
//   resp      : cluster responses, RESP_LAT cycles behind stim
//   busy      : high in SEED/RUN/DRAIN/CMP
//   done      : high in DONE
//   pass      : signature matched golden (valid with done)
//   signature : current MISR value
// -----------------------------------------------------------------------------
module sg13g2_cell_bist
  import sg13g2_bist_pkg::*;
#(
  parameter int unsigned N_IN     = 4,
  parameter int unsigned N_OUT    = 8,
  parameter int unsigned RESP_LAT = 1
) (
  input  logic             cp,
  input  logic             cdn,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      n_pat,
  input  logic [15:0]      seed,
  input  logic [15:0]      golden,
  output logic [N_IN-1:0]  stim,
  output logic             stim_vld,
  input  logic [N_OUT-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
);

  state_t              state_r;
  logic [15:0]         cnt_r;
  logic [15:0]         seed_r;
  logic [1:0]          drn_r;
  logic [RESP_LAT-1:0] pipe_r;
  logic                stim_vld_r;
  logic                busy_r;
  logic                done_r;
  logic                pass_r;

  logic [RESP_LAT:0]   pipe_ext_s;
  logic [15:0]         lfsr_q_s;
  logic [15:0]         misr_q_s;
  logic [15:0]         misr_xin_s;
  logic [15:0]         seed_val_s;
  logic                seed_ld_s;
  logic                lfsr_en_s;
  logic                misr_en_s;

  // Valid pipe input concatenated so any RESP_LAT (including 1) slices cleanly
  assign pipe_ext_s = {pipe_r, stim_vld_r};

  // abort freezes both shift registers so the signature stays readable
  assign seed_ld_s  = (state_r == SEED) && !abort;
  assign lfsr_en_s  = (state_r == RUN) && !abort;
  assign misr_en_s  = pipe_r[RESP_LAT-1] && !abort;
  assign seed_val_s = (seed_r == 16'h0000) ? DEFAULT_SEED : seed_r;

  // Zero-extend the responses to the MISR width
  always_comb begin
    misr_xin_s = 16'h0000;
    misr_xin_s[N_OUT-1:0] = resp;
  end

  sg13g2_bist_lfsr16 #(.RST_VAL(DEFAULT_SEED)) u_lfsr (
    .cp       (cp),
    .cdn      (cdn),
    .load     (seed_ld_s),
    .load_val (seed_val_s),
    .en       (lfsr_en_s),
    .xin      (16'h0000),
    .q        (lfsr_q_s)
  );

  sg13g2_bist_lfsr16 #(.RST_VAL(16'h0000)) u_misr (
    .cp       (cp),
    .cdn      (cdn),
    .load     (seed_ld_s),
    .load_val (16'h0000),
    .en       (misr_en_s),
    .xin      (misr_xin_s),
    .q        (misr_q_s)
  );

  // Controller FSM with pattern counter, drain counter, valid pipe and flags
  always_ff @(posedge cp or negedge cdn) begin
    if (!cdn) begin
      state_r    <= IDLE;
      cnt_r      <= 16'h0000;
      seed_r     <= 16'h0000;
      drn_r      <= 2'd0;
      pipe_r     <= '0;
      stim_vld_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else if (abort) begin
      state_r    <= IDLE;
      pipe_r     <= '0;
      stim_vld_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      pipe_r <= pipe_ext_s[RESP_LAT-1:0];
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= SEED;
            busy_r  <= 1'b1;
            cnt_r   <= n_pat;
            seed_r  <= seed;
          end
        end
        SEED: begin
          pass_r <= 1'b0;
          if (cnt_r != 16'h0000) begin
            state_r    <= RUN;
            stim_vld_r <= 1'b1;
          end else begin
            // No patterns: still spend RESP_LAT cycles in DRAIN
            state_r <= DRAIN;
            drn_r   <= 2'(RESP_LAT - 1);
          end
        end
        RUN: begin
          cnt_r <= cnt_r - 16'd1;
          if (cnt_r == 16'd1) begin
            state_r    <= DRAIN;
            stim_vld_r <= 1'b0;
            drn_r      <= 2'(RESP_LAT - 1);
          end
        end
        DRAIN: begin
          // Last counted response is folded in on the edge leaving DRAIN
          if (drn_r == 2'd0) begin
            state_r <= CMP;
          end else begin
            drn_r <= drn_r - 2'd1;
          end
        end
        CMP: begin
          pass_r  <= (misr_q_s == golden);
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          // Wait for start to drop: no automatic retrigger
          if (!start) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          stim_vld_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          pass_r     <= 1'b0;
        end
      endcase
    end
  end

  assign stim      = lfsr_q_s[N_IN-1:0];
  assign stim_vld  = stim_vld_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = misr_q_s;

endmodule

// File: tb/tb_sg13g2_cell_bist.sv
// -----------------------------------------------------------------------------
// tb_sg13g2_cell_bist
// Two BIST instances (RESP_LAT = 1 and 3) each driving a behavioural cell
// cluster whose response is a function of the stimulus delayed by RESP_LAT
// clocks. Expected signatures come from a pattern-list model of the BIST.
// -----------------------------------------------------------------------------
module tb_sg13g2_cell_bist;

  logic        cp = 1'b0;
  logic        cdn = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] n_pat = 16'h0000;
  logic [15:0] seed = 16'h0000;
  logic [15:0] golden = 16'h0000;

  logic [3:0]  stim_a, stim_b;
  logic        vld_a, vld_b;
  logic [7:0]  resp_a, resp_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] sig_a, sig_b;

  logic [7:0]  key = 8'h00;
  int          mode = 0;

  logic [3:0]  ca_q = 4'h0;
  logic [3:0]  cb_q1 = 4'h0, cb_q2 = 4'h0, cb_q3 = 4'h0;

  int total = 0;
  int bad = 0;

  logic [3:0]  got_stim[$];
  logic [3:0]  exp_stim[$];

  always #5 cp = ~cp;

  // Cell cluster: combinational function of the stimulus seen RESP_LAT clocks earlier
  function automatic logic [7:0] cell_fn(input logic [3:0] s, input logic [7:0] k, input int m);
    case (m)
      0:       return 8'h00;
      1:       return {4'h0, s};
      default: return {s ^ k[7:4], s + k[3:0]};
    endcase
  endfunction

  // Cell pipeline registers (one stage for instance a, three for instance b)
  always @(posedge cp) begin
    ca_q  <= stim_a;
    cb_q1 <= stim_b;
    cb_q2 <= cb_q1;
    cb_q3 <= cb_q2;
  end

  assign resp_a = cell_fn(ca_q, key, mode);
  assign resp_b = cell_fn(cb_q3, key, mode);

  sg13g2_cell_bist #(.N_IN(4), .N_OUT(8), .RESP_LAT(1)) dut_a (
    .cp(cp), .cdn(cdn), .start(start_a), .abort(abort), .n_pat(n_pat),
    .seed(seed), .golden(golden), .stim(stim_a), .stim_vld(vld_a),
    .resp(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a)
  );

  sg13g2_cell_bist #(.N_IN(4), .N_OUT(8), .RESP_LAT(3)) dut_b (
    .cp(cp), .cdn(cdn), .start(start_b), .abort(abort), .n_pat(n_pat),
    .seed(seed), .golden(golden), .stim(stim_b), .stim_vld(vld_b),
    .resp(resp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b)
  );

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
  function automatic logic [15:0] poly_step(input logic [15:0] x);
    logic fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return (x << 1) | {15'h0000, fb};
  endfunction

  // Reference: list of applied patterns and the signature folded over their responses
  task automatic model_run(input logic [15:0] sd, input int n, input logic [7:0] k,
                           input int m, output logic [15:0] sig);
    logic [15:0] l;
    l = (sd == 16'h0000) ? 16'h0001 : sd;
    sig = 16'h0000;
    exp_stim.delete();
    for (int i = 0; i < n; i++) begin
      exp_stim.push_back(l[3:0]);
      sig = poly_step(sig) ^ {8'h00, cell_fn(l[3:0], k, m)};
      l = poly_step(l);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] o_sig(input int sel);
    return (sel != 0) ? sig_b : sig_a;
  endfunction
  function automatic logic o_done(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction
  function automatic logic o_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic o_vld(input int sel);
    return (sel != 0) ? vld_b : vld_a;
  endfunction
  function automatic logic o_pass(input int sel);
    return (sel != 0) ? pass_b : pass_a;
  endfunction
  function automatic logic [3:0] o_stim(input int sel);
    return (sel != 0) ? stim_b : stim_a;
  endfunction

  // Full start/done handshake on one instance, checked against the model
  task automatic run_case(input int sel, input logic [15:0] sd, input logic [15:0] n,
                          input logic [7:0] k, input int m, input logic [15:0] gdelta,
                          input logic exp_pass, input string name);
    logic [15:0] msig;
    int lat, cyc, limit;
    logic fin;
    model_run(sd, int'(n), k, m, msig);
    lat = (sel != 0) ? 3 : 1;
    @(negedge cp);
    seed = sd; n_pat = n; golden = msig ^ gdelta; key = k; mode = m;
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    got_stim.delete();
    cyc = 0; fin = 1'b0;
    limit = int'(n) + lat + 20;
    while (!fin && cyc < limit) begin
      @(posedge cp);
      @(negedge cp);
      cyc++;
      if (cyc == 1) check({name, "_busy"}, {31'd0, o_busy(sel)}, 32'd1);
      if (o_vld(sel)) got_stim.push_back(o_stim(sel));
      if (o_done(sel)) fin = 1'b1;
    end
    check({name, "_latency"}, cyc, int'(n) + lat + 3);
    check({name, "_sig"}, {16'h0, o_sig(sel)}, {16'h0, msig});
    check({name, "_pass"}, {31'd0, o_pass(sel)}, {31'd0, exp_pass});
    check({name, "_npat"}, got_stim.size(), exp_stim.size());
    for (int i = 0; i < got_stim.size() && i < exp_stim.size(); i++)
      check({name, "_stim"}, {28'd0, got_stim[i]}, {28'd0, exp_stim[i]});
    // start still high: DONE holds, no retrigger
    repeat (2) @(negedge cp);
    check({name, "_hold_done"}, {31'd0, o_done(sel)}, 32'd1);
    check({name, "_hold_sig"}, {16'h0, o_sig(sel)}, {16'h0, msig});
    start_a = 1'b0; start_b = 1'b0;
    @(negedge cp);
    check({name, "_idle_done"}, {31'd0, o_done(sel)}, 32'd0);
    check({name, "_idle_busy"}, {31'd0, o_busy(sel)}, 32'd0);
  endtask

  typedef struct {
    int          sel;
    logic [15:0] seed;
    logic [15:0] n;
    logic [7:0]  key;
    int          mode;
    logic [15:0] gdelta;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] seq12[12];

  initial begin
    logic [15:0] msig, sig_before, rs, rd;
    logic [7:0]  rk;
    int          rn, rm, rsel, cnt, guard;

    vecs[0] = '{0, 16'h0000, 16'd12, 8'h00, 1, 16'h0000, 1'b1};
    vecs[1] = '{0, 16'h1234, 16'd5,  8'h00, 0, 16'h0000, 1'b1};
    vecs[2] = '{0, 16'h0001, 16'd4,  8'h00, 1, 16'h0000, 1'b1};
    vecs[3] = '{0, 16'h0001, 16'd4,  8'h00, 1, 16'h0001, 1'b0};
    vecs[4] = '{0, 16'hACE1, 16'd0,  8'h00, 1, 16'h0000, 1'b1};
    vecs[5] = '{0, 16'hFFFF, 16'd1,  8'hA5, 2, 16'h0000, 1'b1};
    vecs[6] = '{1, 16'h0BEE, 16'd20, 8'h3C, 2, 16'h0000, 1'b1};
    vecs[7] = '{0, 16'h0BEE, 16'd20, 8'h3C, 2, 16'h0000, 1'b1};
    seq12 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};

    // Reset with start high: everything 0 except stim = 1
    start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(negedge cp);
    check("rst_stim_a", {28'd0, stim_a}, 32'h1);
    check("rst_stim_b", {28'd0, stim_b}, 32'h1);
    check("rst_outs_a", {26'd0, vld_a, busy_a, done_a, pass_a, 2'b00}, 32'd0);
    check("rst_sig_a", {16'h0, sig_a}, 32'd0);
    check("rst_outs_b", {28'd0, vld_b, busy_b, done_b, pass_b}, 32'd0);
    start_a = 1'b0; start_b = 1'b0;
    @(negedge cp);
    cdn = 1'b1;
    @(negedge cp);

    for (int i = 0; i < 8; i++) begin
      run_case(vecs[i].sel, vecs[i].seed, vecs[i].n, vecs[i].key, vecs[i].mode,
               vecs[i].gdelta, vecs[i].exp_pass, $sformatf("vec%0d", i));
      if (i == 0)
        for (int j = 0; j < 12 && j < got_stim.size(); j++)
          check("seed0_seq", {28'd0, got_stim[j]}, {28'd0, seq12[j]});
      if (i == 1) check("zero_resp_sig", {16'h0, sig_a}, 32'd0);
      if (i == 4) check("npat0_sig", {16'h0, sig_a}, 32'd0);
    end

    // Randomized runs on both latencies
    for (int r = 0; r < 8; r++) begin
      rs   = 16'($urandom);
      rn   = $urandom_range(1, 40);
      rk   = 8'($urandom);
      rm   = $urandom_range(0, 2);
      rsel = $urandom_range(0, 1);
      rd   = ($urandom_range(0, 1) == 1) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
      run_case(rsel, rs, 16'(rn), rk, rm, rd, (rd == 16'h0000), $sformatf("rnd%0d", r));
    end

    // Abort on the third RUN cycle, then rerun from the same seed
    model_run(16'h5A5A, 10, 8'h69, 2, msig);
    @(negedge cp);
    seed = 16'h5A5A; n_pat = 16'd10; golden = msig; key = 8'h69; mode = 2;
    start_a = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 3 && guard < 20) begin
      @(negedge cp);
      guard++;
      if (vld_a) cnt++;
    end
    check("abort_reach_run3", cnt, 3);
    sig_before = sig_a;
    abort = 1'b1; start_a = 1'b0;
    @(negedge cp);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_done", {31'd0, done_a}, 32'd0);
    check("abort_vld", {31'd0, vld_a}, 32'd0);
    check("abort_sig_hold", {16'h0, sig_a}, {16'h0, sig_before});
    @(negedge cp);
    check("abort_stays_idle", {31'd0, busy_a}, 32'd0);
    run_case(0, 16'h5A5A, 16'd10, 8'h69, 2, 16'h0000, 1'b1, "after_abort");

    // Asynchronous reset in the middle of DRAIN (RESP_LAT = 3 instance)
    @(negedge cp);
    seed = 16'h1357; n_pat = 16'd5; key = 8'hC3; mode = 2;
    start_b = 1'b1;
    cnt = 0; guard = 0;
    while (!(cnt > 0 && !vld_b && busy_b) && guard < 20) begin
      @(negedge cp);
      guard++;
      if (vld_b) cnt++;
    end
    check("drain_reached", {31'd0, busy_b && !vld_b}, 32'd1);
    @(negedge cp);
    #2 cdn = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy_b}, 32'd0);
    check("arst_stim", {28'd0, stim_b}, 32'h1);
    check("arst_sig", {16'h0, sig_b}, 32'd0);
    check("arst_flags", {29'd0, vld_b, done_b, pass_b}, 32'd0);
    start_b = 1'b0;
    @(negedge cp);
    cdn = 1'b1;
    @(negedge cp);
    check("arst_after_idle", {31'd0, busy_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sg13g2_cell_bist.md
Name: sg13g2_cell_bist

Overview:
- On-chip built-in self-test (BIST) stage for the sg13g2 characterisation die.
- Drives pseudo-random stimulus into a cell-under-test cluster built from the library gates and flops.
- Compacts the cluster's responses into a 16-bit signature using a multiple-input signature register (MISR).
- Compares the signature against a golden value and reports pass/fail over a start/done handshake.

Parameters:
N_IN, 4, stimulus width driven to cells under test (1..16)
N_OUT, 8, response width captured from cells under test (1..16)
RESP_LAT, 1, cycles from stim change to valid resp (1..4)

Ports:
cp  input  1  clock, rising edge
cdn  input  1  reset; asynchronous assert, active-low
start  input  1  level request; sampled only in IDLE
abort  input  1  synchronous abort, any state
n_pat  input  16  number of patterns to apply; sampled on start
seed  input  16  LFSR seed; sampled on start
golden  input  16  expected signature; sampled in CMP
stim  output  N_IN  stimulus to cells = lfsr[N_IN-1:0]
stim_vld  output  1  stim holds a counted pattern this cycle
resp  input  N_OUT  cell responses
busy  output  1  high in SEED/RUN/DRAIN/CMP
done  output  1  high in DONE
pass  output  1  valid when done; signature == golden
signature  output  16  current MISR value

Behaviour:
- Reset (cdn=0):
  - state=IDLE, lfsr=16'h0001, misr=0, cnt=0, valid pipe=0.
  - All outputs 0, except stim = 16'h0001[N_IN-1:0].
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances only in RUN.
- MISR: next = {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ {16-N_OUT zeros, resp}.
  - Updates only when valid-pipe tail = 1.
- Valid pipe: RESP_LAT-deep shift register of stim_vld; its tail marks the cycle in which resp corresponds to a counted pattern.
- FSM:
  - IDLE: start=1 -> SEED.
  - SEED (1 cycle): lfsr <= (seed==0 ? 16'h0001 : seed); misr <= 0; cnt <= n_pat; pass <= 0. Next: RUN if n_pat!=0, else DRAIN.
  - RUN: stim_vld=1; lfsr advances; cnt decrements. Exactly n_pat cycles; at cnt==1 -> DRAIN.
  - DRAIN: stim_vld=0; lfsr holds. Stays until the valid pipe is empty, i.e. exactly RESP_LAT cycles after the last RUN cycle; n_pat=0 also spends RESP_LAT cycles. Then -> CMP.
  - CMP (1 cycle): pass <= (misr == golden) -> DONE.
  - DONE: done=1; pass and signature hold. start=0 -> IDLE. start still 1 -> stay in DONE; no auto-retrigger.
- abort=1 in any state: next state IDLE, valid pipe cleared, done=0, pass=0. lfsr and misr hold; signature stays readable. abort has priority over start.
- Latency: start -> first stim_vld = 2 cycles; start -> done = n_pat + RESP_LAT + 3 cycles.
- cnt is 16-bit; n_pat = 16'hFFFF runs 65535 patterns with no wrap.
- IDLE and DONE: stim holds the last lfsr value; no MISR updates.
- Asynchronous reset mid-run: returns immediately to reset values; nothing is retained.

Decomposition:
- Shared package sg13g2_bist_pkg:
  - state enum: IDLE, SEED, RUN, DRAIN, CMP, DONE;
  - LFSR/MISR width constant 16;
  - tap mask constant 16'hB400;
  - default seed 16'h0001.
- One sub-module, sg13g2_bist_lfsr16: 16-bit shift register with tap mask, parallel load, enable, optional XOR-in vector.
  - Instantiated twice: as the stimulus LFSR (XOR-in = 0) and as the MISR (XOR-in = resp).
- FSM, counter and valid pipe live in the top module.

Test Plan:
- Reset and seed: cdn low with start=1 -> all outputs 0, stim=4'h1. Release, start with seed=0, n_pat=12 -> stim sequence 1,2,4,8,0,...,0 (LFSR 0x0001..0x0400, then 0x0801).
- Resp tied 0, n_pat=5, golden=0 -> signature 0x0000, pass=1, done exactly 5+1+3 = 9 cycles after start.
- Resp = stim looped back (N_OUT=N_IN=4), seed=1, n_pat=4 -> signature equals reference-model value. Rerun with golden off by one bit -> pass=0.
- n_pat=0 -> stim_vld never asserts, signature=0, done 4 cycles after start (RESP_LAT=1).
- abort asserted on 3rd RUN cycle -> next cycle busy=0, done=0, state IDLE. Restart with same seed -> identical signature to an uninterrupted run.
- RESP_LAT=3, resp = 3-cycle-delayed stim, n_pat=20 -> signature matches the RESP_LAT=1 zero-delay run. Asynchronous cdn pulse mid-DRAIN -> immediate reset values.
